led_flash_pwm: RTL and testbench

//  Multi-channel LED blink/PWM generator with per-channel run-time configuration.
//  A shared prescaler tick drives NCH independent period counters. Each channel

---
 rtl/led_flash_pwm.sv | 174 +++++++++++++++++
 tb/tb_led_flash_pwm.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_flash_pwm.sv
// Multi-channel LED blink/PWM generator with double-buffered per-channel config.
// New settings land at a period boundary (or at once from OFF/ON) so LEDs never glitch.
module led_flash_pwm #(
  parameter int NCH      = 4,
  parameter int CW       = 16,
  parameter int PRESCALE = 1,
  parameter int BW       = 8,
  parameter int ACT_LOW  = 0,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_we,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [1:0]     cfg_mode,
  input  logic [CW-1:0]  cfg_on,
  input  logic [CW-1:0]  cfg_period,
  input  logic [BW-1:0]  cfg_burst,
  output logic [NCH-1:0] cfg_pending,
  output logic [NCH-1:0] burst_done,
  output logic [NCH-1:0] led_out
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_PWM   = 2'b10,
    MODE_BURST = 2'b11
  } mode_t;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [NCH-1:0] INACTIVE = (ACT_LOW != 0) ? {NCH{1'b1}} : {NCH{1'b0}};

  logic [PW-1:0]  pre_cnt;
  logic           tick;

  mode_t          mode       [NCH];
  mode_t          mode_nx    [NCH];
  logic [CW-1:0]  on_time    [NCH];
  logic [CW-1:0]  on_nx      [NCH];
  logic [CW-1:0]  period     [NCH];
  logic [CW-1:0]  period_nx  [NCH];
  logic [CW-1:0]  cnt        [NCH];
  logic [CW-1:0]  cnt_nx     [NCH];
  logic [CW-1:0]  p_last     [NCH];
  logic [BW-1:0]  burst_left [NCH];
  logic [BW-1:0]  burst_nx   [NCH];

  mode_t          sh_mode    [NCH];
  logic [CW-1:0]  sh_on      [NCH];
  logic [CW-1:0]  sh_period  [NCH];
  logic [BW-1:0]  sh_burst   [NCH];

  logic [NCH-1:0] wr;
  logic [NCH-1:0] running;
  logic [NCH-1:0] eop;
  logic [NCH-1:0] pending_nx;
  logic [NCH-1:0] done_nx;
  logic [NCH-1:0] level;

  assign tick = (pre_cnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) pre_cnt <= '0;
    else             pre_cnt <= pre_cnt + 1'b1;
  end

  // Period 0 behaves like period 1, so the last count index is clamped at 0.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      wr[i]      = cfg_we && (int'(cfg_ch) == i);
      p_last[i]  = (period[i] == '0) ? '0 : period[i] - 1'b1;
      running[i] = (mode[i] == MODE_PWM) || (mode[i] == MODE_BURST);
      eop[i]     = running[i] && tick && (cnt[i] >= p_last[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst) begin
        sh_mode[i]   <= MODE_OFF;
        sh_on[i]     <= '0;
        sh_period[i] <= '0;
        sh_burst[i]  <= '0;
      end else if (wr[i]) begin
        sh_mode[i]   <= mode_t'(cfg_mode);
        sh_on[i]     <= cfg_on;
        sh_period[i] <= cfg_period;
        sh_burst[i]  <= cfg_burst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        mode[i]       <= MODE_OFF;
        on_time[i]    <= '0;
        period[i]     <= '0;
        cnt[i]        <= '0;
        burst_left[i] <= '0;
      end
      cfg_pending <= '0;
      burst_done  <= '0;
      led_out     <= INACTIVE;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        mode[i]       <= mode_nx[i];
        on_time[i]    <= on_nx[i];
        period[i]     <= period_nx[i];
        cnt[i]        <= cnt_nx[i];
        burst_left[i] <= burst_nx[i];
      end
      cfg_pending <= pending_nx;
      burst_done  <= done_nx;
      led_out     <= level ^ INACTIVE;
    end
  end

  // A transfer overrides the counter/burst update of the same cycle; a write in that
  // cycle still lands in the shadow and keeps the channel pending.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      mode_nx[i]    = mode[i];
      on_nx[i]      = on_time[i];
      period_nx[i]  = period[i];
      cnt_nx[i]     = cnt[i];
      burst_nx[i]   = burst_left[i];
      pending_nx[i] = cfg_pending[i];
      done_nx[i]    = 1'b0;

      if (running[i] && tick)
        cnt_nx[i] = eop[i] ? '0 : cnt[i] + 1'b1;

      if ((mode[i] == MODE_BURST) && eop[i]) begin
        if (burst_left[i] <= BW'(1)) begin
          mode_nx[i]  = MODE_OFF;
          burst_nx[i] = '0;
          done_nx[i]  = 1'b1;
        end else begin
          burst_nx[i] = burst_left[i] - 1'b1;
        end
      end

      if (cfg_pending[i] && (!running[i] || eop[i])) begin
        mode_nx[i]    = sh_mode[i];
        on_nx[i]      = sh_on[i];
        period_nx[i]  = sh_period[i];
        cnt_nx[i]     = '0;
        burst_nx[i]   = sh_burst[i];
        pending_nx[i] = 1'b0;
        if ((sh_mode[i] == MODE_BURST) && (sh_burst[i] == '0)) begin
          mode_nx[i] = MODE_OFF;
          done_nx[i] = 1'b1;
        end
      end

      if (wr[i])
        pending_nx[i] = 1'b1;
    end
  end

  always_comb begin
    level = '0;
    for (int i = 0; i < NCH; i++) begin
      case (mode[i])
        MODE_OFF: level[i] = 1'b0;
        MODE_ON:  level[i] = 1'b1;
        default:  level[i] = (cnt[i] < on_time[i]);
      endcase
    end
  end

endmodule

// File: tb/tb_led_flash_pwm.sv
// Directed bench for led_flash_pwm: one instance at PRESCALE=1/active-high,
// a second at NCH=3, PRESCALE=5, active-low for prescaler and channel-range cases.
module tb_led_flash_pwm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cfg_we;
  logic [1:0]  cfg_ch, cfg_mode;
  logic [15:0] cfg_on, cfg_period;
  logic [7:0]  cfg_burst;
  logic [3:0]  cfg_pending, burst_done, led_out;

  logic        rst_p, p_we;
  logic [1:0]  p_ch, p_mode;
  logic [15:0] p_on, p_period;
  logic [7:0]  p_burst;
  logic [2:0]  p_pending, p_done, p_led;

  int checks = 0;
  int errors = 0;

  led_flash_pwm #(.NCH(4), .CW(16), .PRESCALE(1), .BW(8), .ACT_LOW(0)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_on(cfg_on), .cfg_period(cfg_period), .cfg_burst(cfg_burst),
    .cfg_pending(cfg_pending), .burst_done(burst_done), .led_out(led_out)
  );

  led_flash_pwm #(.NCH(3), .CW(16), .PRESCALE(5), .BW(8), .ACT_LOW(1)) dut_p (
    .clk(clk), .rst(rst_p), .cfg_we(p_we), .cfg_ch(p_ch), .cfg_mode(p_mode),
    .cfg_on(p_on), .cfg_period(p_period), .cfg_burst(p_burst),
    .cfg_pending(p_pending), .burst_done(p_done), .led_out(p_led)
  );

  task automatic write_cfg(input logic [1:0] ch, input logic [1:0] mode,
                           input logic [15:0] on, input logic [15:0] per,
                           input logic [7:0] burst);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode;
    cfg_on = on; cfg_period = per; cfg_burst = burst;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic write_cfg_p(input logic [1:0] ch, input logic [1:0] mode,
                             input logic [15:0] on, input logic [15:0] per,
                             input logic [7:0] burst);
    p_we = 1'b1; p_ch = ch; p_mode = mode;
    p_on = on; p_period = per; p_burst = burst;
    @(posedge clk); #1;
    p_we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst_p = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cfg_we = (i != 1); cfg_ch = 2'd0; cfg_mode = 2'b01;
      p_we   = (i != 1); p_ch   = 2'd0; p_mode   = 2'b01;
      @(posedge clk); #1;
      checks++;
      if ({led_out, cfg_pending, burst_done} !== 12'h000) begin
        errors++;
        $display("[TB] FAIL reset_main cycle %0d: led/pend/done=%h expected 000", i,
                 {led_out, cfg_pending, burst_done});
      end
      checks++;
      if ({p_led, p_pending, p_done} !== 9'b111_000_000) begin
        errors++;
        $display("[TB] FAIL reset_lowact cycle %0d: led/pend/done=%b expected 111000000", i,
                 {p_led, p_pending, p_done});
      end
    end
    rst = 1'b0; rst_p = 1'b0; cfg_we = 1'b0; p_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({led_out, cfg_pending} !== 8'h00) begin
        errors++;
        $display("[TB] FAIL reset_release %0d: led/pend=%h expected 00", i, {led_out, cfg_pending});
      end
      checks++;
      if ({p_led, p_pending} !== 6'b111_000) begin
        errors++;
        $display("[TB] FAIL reset_release_p %0d: led/pend=%b expected 111000", i, {p_led, p_pending});
      end
    end
  endtask

  task automatic test_pwm;
    logic exp;
    write_cfg(2'd0, 2'b10, 16'd3, 16'd8, 8'd0);
    checks++;
    if (cfg_pending[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL pwm_pending_set: got %b expected 1", cfg_pending[0]);
    end
    @(posedge clk); #1;
    checks++;
    if ({cfg_pending[0], led_out[0]} !== 2'b00) begin
      errors++; $display("[TB] FAIL pwm_transfer: pend/led=%b expected 00", {cfg_pending[0], led_out[0]});
    end
    for (int j = 0; j < 16; j++) begin
      @(posedge clk); #1;
      exp = ((j % 8) < 3);
      checks++;
      if (led_out[0] !== exp) begin
        errors++; $display("[TB] FAIL pwm_pattern step %0d: got %b expected %b", j, led_out[0], exp);
      end
    end
  endtask

  task automatic test_glitch_free;
    logic exp_led, exp_pend;
    repeat (2) begin @(posedge clk); #1; end
    write_cfg(2'd0, 2'b10, 16'd6, 16'd8, 8'd0);
    checks++;
    if ({cfg_pending[0], led_out[0]} !== 2'b11) begin
      errors++; $display("[TB] FAIL glitch_write: pend/led=%b expected 11", {cfg_pending[0], led_out[0]});
    end
    for (int d = 1; d <= 13; d++) begin
      @(posedge clk); #1;
      exp_led  = (d >= 6) && (d <= 11);
      exp_pend = (d <= 4);
      checks++;
      if (led_out[0] !== exp_led) begin
        errors++; $display("[TB] FAIL glitch_led d=%0d: got %b expected %b", d, led_out[0], exp_led);
      end
      checks++;
      if (cfg_pending[0] !== exp_pend) begin
        errors++; $display("[TB] FAIL glitch_pend d=%0d: got %b expected %b", d, cfg_pending[0], exp_pend);
      end
    end
  endtask

  task automatic test_burst;
    logic exp_led, exp_done;
    write_cfg(2'd1, 2'b11, 16'd1, 16'd4, 8'd3);
    checks++;
    if ({cfg_pending[1], led_out[1]} !== 2'b10) begin
      errors++; $display("[TB] FAIL burst_write: pend/led=%b expected 10", {cfg_pending[1], led_out[1]});
    end
    for (int d = 1; d <= 20; d++) begin
      @(posedge clk); #1;
      exp_led  = (d == 2) || (d == 6) || (d == 10);
      exp_done = (d == 13);
      checks++;
      if (led_out[1] !== exp_led) begin
        errors++; $display("[TB] FAIL burst_led d=%0d: got %b expected %b", d, led_out[1], exp_led);
      end
      checks++;
      if (burst_done[1] !== exp_done) begin
        errors++; $display("[TB] FAIL burst_done d=%0d: got %b expected %b", d, burst_done[1], exp_done);
      end
    end
  endtask

  task automatic test_edges;
    logic exp;
    write_cfg(2'd2, 2'b10, 16'd0, 16'd8, 8'd0);
    for (int d = 1; d <= 10; d++) begin
      @(posedge clk); #1;
      checks++;
      if (led_out[2] !== 1'b0) begin
        errors++; $display("[TB] FAIL edge_on0 d=%0d: got %b expected 0", d, led_out[2]);
      end
      if (d == 1) begin
        checks++;
        if (cfg_pending[2] !== 1'b0) begin
          errors++; $display("[TB] FAIL edge_on0_pend: got %b expected 0", cfg_pending[2]);
        end
      end
    end
    write_cfg(2'd3, 2'b10, 16'd9, 16'd8, 8'd0);
    for (int d = 1; d <= 11; d++) begin
      @(posedge clk); #1;
      exp = (d >= 2);
      checks++;
      if (led_out[3] !== exp) begin
        errors++; $display("[TB] FAIL edge_on_gt_period d=%0d: got %b expected %b", d, led_out[3], exp);
      end
    end
    write_cfg(2'd1, 2'b10, 16'd1, 16'd0, 8'd0);
    for (int d = 1; d <= 11; d++) begin
      @(posedge clk); #1;
      exp = (d >= 2);
      checks++;
      if (led_out[1] !== exp) begin
        errors++; $display("[TB] FAIL edge_period0 d=%0d: got %b expected %b", d, led_out[1], exp);
      end
    end
  endtask

  task automatic test_prescaler;
    logic act;
    rst_p = 1'b1;
    @(posedge clk); #1;
    rst_p = 1'b0;
    write_cfg_p(2'd0, 2'b10, 16'd2, 16'd4, 8'd0);
    for (int n = 2; n <= 40; n++) begin
      @(posedge clk); #1;
      act = ((n >= 3) && (n <= 10)) || ((n >= 21) && (n <= 30));
      checks++;
      if (p_led !== {2'b11, ~act}) begin
        errors++; $display("[TB] FAIL prescale_led n=%0d: got %b expected %b", n, p_led, {2'b11, ~act});
      end
    end
  endtask

  task automatic test_bad_channel;
    write_cfg_p(2'd3, 2'b01, 16'd1, 16'd1, 8'd0);
    for (int d = 0; d <= 5; d++) begin
      checks++;
      if (p_pending !== 3'b000) begin
        errors++; $display("[TB] FAIL badch_pend d=%0d: got %b expected 000", d, p_pending);
      end
      checks++;
      if (p_led[2:1] !== 2'b11) begin
        errors++; $display("[TB] FAIL badch_led d=%0d: got %b expected 11", d, p_led[2:1]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midburst;
    write_cfg(2'd1, 2'b11, 16'd1, 16'd4, 8'd3);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_mode = 2'b01;
    @(posedge clk); #1;
    rst = 1'b0; cfg_we = 1'b0;
    for (int d = 0; d <= 8; d++) begin
      checks++;
      if ({led_out, cfg_pending, burst_done} !== 12'h000) begin
        errors++; $display("[TB] FAIL midburst_reset d=%0d: led/pend/done=%h expected 000", d,
                           {led_out, cfg_pending, burst_done});
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; rst_p = 1'b1;
    cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_on = '0; cfg_period = '0; cfg_burst = '0;
    p_we = 1'b0; p_ch = '0; p_mode = '0; p_on = '0; p_period = '0; p_burst = '0;
    test_reset();
    test_pwm();
    test_glitch_free();
    test_burst();
    test_edges();
    test_prescaler();
    test_bad_channel();
    test_reset_midburst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
